// File: rtl/sram_arb.sv
// sram_arb: on-chip 32-bit SRAM shared by two native-memory requesters
// (port 0 = CPU, port 1 = DMA/debug). Round-robin arbitration, byte-strobed
// writes, WAIT_STATES extra cycles before the access, one-cycle ready pulse.
// Optional build macro SRAM_PARITY_EN: per-byte even parity with err report;
// when undefined p0_err/p1_err are constant 0.
module sram_arb #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DEPTH       = 2048,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_valid,
  input  logic [3:0]            p0_wstrb,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [31:0]           p0_wdata,
  output logic                  p0_ready,
  output logic [31:0]           p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_valid,
  input  logic [3:0]            p1_wstrb,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [31:0]           p1_wdata,
  output logic                  p1_ready,
  output logic [31:0]           p1_rdata,
  output logic                  p1_err
);

  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              port_q, port_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              p0_ready_q, p0_ready_d;
  logic              p1_ready_q, p1_ready_d;
  logic [31:0]       p0_rdata_q, p0_rdata_d;
  logic [31:0]       p1_rdata_q, p1_rdata_d;
  logic              p0_err_q, p0_err_d;
  logic              p1_err_q, p1_err_d;

  logic [31:0]       mem [DEPTH];
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;
  logic [31:0]       rd_word;
  logic              rd_err;
  logic              do_write;

  // Byte-offset address bits play no part in word addressing.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{p0_addr[1:0], p1_addr[1:0]};

  // Latched word index decode and out-of-range detection.
  always_comb begin
    mem_idx  = idx_q[MEM_AW-1:0];
    in_range = (32'(idx_q) < 32'(DEPTH));
    rd_word  = in_range ? mem[mem_idx] : '0;
  end

`ifdef SRAM_PARITY_EN
  logic [3:0] par [DEPTH];
  logic [3:0] rd_par;

  // Recompute even parity over the read word and compare with stored bits.
  always_comb begin
    rd_par = '0;
    for (int unsigned b = 0; b < 4; b++) begin
      rd_par[b] = ^rd_word[8*b +: 8];
    end
    rd_err = in_range && (rd_par != par[mem_idx]);
  end

  // Storage write: only strobed bytes and their parity bits change.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
          par[mem_idx][b]        <= ^wdata_q[8*b +: 8];
        end
      end
    end
  end
`else
  assign rd_err = 1'b0;

  // Storage write: only strobed bytes change.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb_q[b]) begin
          mem[mem_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end
`endif

  // Arbitration FSM: grant in IDLE, optional wait, access, one-cycle response.
  // ready/rdata/err are registered at the ACCESS edge so they appear in RESP.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    idx_d        = idx_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    p0_ready_d   = 1'b0;
    p1_ready_d   = 1'b0;
    p0_err_d     = 1'b0;
    p1_err_d     = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    do_write     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p0_valid || p1_valid) begin
          if (p0_valid && p1_valid) begin
            port_d = ~last_grant_q;
          end else begin
            port_d = p1_valid;
          end
          last_grant_d = port_d;
          idx_d        = port_d ? p1_addr[ADDR_WIDTH-1:2] : p0_addr[ADDR_WIDTH-1:2];
          wstrb_d      = port_d ? p1_wstrb : p0_wstrb;
          wdata_d      = port_d ? p1_wdata : p0_wdata;
          cnt_d        = '0;
          state_d      = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'(WAIT_STATES - 1)) begin
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_ACCESS: begin
        do_write = (wstrb_q != '0) && in_range;
        if (port_q) begin
          p1_ready_d = 1'b1;
          if (wstrb_q == '0) begin
            p1_rdata_d = rd_word;
            p1_err_d   = rd_err;
          end
        end else begin
          p0_ready_d = 1'b1;
          if (wstrb_q == '0) begin
            p0_rdata_d = rd_word;
            p0_err_d   = rd_err;
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers; last_grant resets to 1 so port 0 wins first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      idx_q        <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      p0_ready_q   <= 1'b0;
      p1_ready_q   <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      p0_err_q     <= 1'b0;
      p1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      idx_q        <= idx_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      p0_ready_q   <= p0_ready_d;
      p1_ready_q   <= p1_ready_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_err_q     <= p0_err_d;
      p1_err_q     <= p1_err_d;
    end
  end

  assign p0_ready = p0_ready_q;
  assign p1_ready = p1_ready_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed bench for sram_arb. dut0 has no wait states, dut1 has
// three; both use a 14-bit address so word index 2048 is reachable.
module tb_sram_arb;

  logic        clk = 1'b0;
  logic        s_reset [2];
  logic        s_valid [2][2];
  logic [3:0]  s_wstrb [2][2];
  logic [13:0] s_addr  [2][2];
  logic [31:0] s_wdata [2][2];
  logic        s_ready [2][2];
  logic [31:0] s_rdata [2][2];
  logic        s_err   [2][2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_arb #(.ADDR_WIDTH(14), .DEPTH(2048), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(s_reset[0]),
    .p0_valid(s_valid[0][0]), .p0_wstrb(s_wstrb[0][0]), .p0_addr(s_addr[0][0]),
    .p0_wdata(s_wdata[0][0]), .p0_ready(s_ready[0][0]), .p0_rdata(s_rdata[0][0]),
    .p0_err(s_err[0][0]),
    .p1_valid(s_valid[0][1]), .p1_wstrb(s_wstrb[0][1]), .p1_addr(s_addr[0][1]),
    .p1_wdata(s_wdata[0][1]), .p1_ready(s_ready[0][1]), .p1_rdata(s_rdata[0][1]),
    .p1_err(s_err[0][1])
  );

  sram_arb #(.ADDR_WIDTH(14), .DEPTH(2048), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(s_reset[1]),
    .p0_valid(s_valid[1][0]), .p0_wstrb(s_wstrb[1][0]), .p0_addr(s_addr[1][0]),
    .p0_wdata(s_wdata[1][0]), .p0_ready(s_ready[1][0]), .p0_rdata(s_rdata[1][0]),
    .p0_err(s_err[1][0]),
    .p1_valid(s_valid[1][1]), .p1_wstrb(s_wstrb[1][1]), .p1_addr(s_addr[1][1]),
    .p1_wdata(s_wdata[1][1]), .p1_ready(s_ready[1][1]), .p1_rdata(s_rdata[1][1]),
    .p1_err(s_err[1][1])
  );

  task automatic do_reset(input int d);
    s_reset[d] = 1'b1;
    s_valid[d][0] = 1'b0;
    s_valid[d][1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    s_reset[d] = 1'b0;
  endtask

  // One transaction on dut d, port p, starting with the FSM idle. lat counts
  // edges from raising valid until ready is visible (-1 on timeout).
  task automatic xact(input int d, input int p, input logic [13:0] addr,
                      input logic [3:0] wstrb, input logic [31:0] wdata,
                      input bit mutate, output int lat, output logic [31:0] rdata,
                      output logic err, output logic other, output logic after);
    lat = -1; rdata = '0; err = 1'b0; other = 1'b0; after = 1'b0;
    s_addr[d][p] = addr; s_wstrb[d][p] = wstrb; s_wdata[d][p] = wdata;
    s_valid[d][p] = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1 && mutate) begin
        s_addr[d][p]  = addr ^ 14'h0004;
        s_wdata[d][p] = ~wdata;
      end
      if (s_ready[d][p] === 1'b1) begin
        lat = n; rdata = s_rdata[d][p]; err = s_err[d][p]; other = s_ready[d][1-p];
        break;
      end
    end
    s_valid[d][p] = 1'b0;
    @(posedge clk); #1;
    after = s_ready[d][p];
  endtask

  task automatic test_reset;
    do_reset(0);
    do_reset(1);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (s_ready[d][p] !== 1'b0) begin errors++; $display("FAIL reset_ready d%0d p%0d: got %b want 0", d, p, s_ready[d][p]); end
        checks++;
        if (s_rdata[d][p] !== 32'h0) begin errors++; $display("FAIL reset_rdata d%0d p%0d: got %h want 0", d, p, s_rdata[d][p]); end
        checks++;
        if (s_err[d][p] !== 1'b0) begin errors++; $display("FAIL reset_err d%0d p%0d: got %b want 0", d, p, s_err[d][p]); end
      end
    end
  endtask

  task automatic test_write_read;
    int lat; logic [31:0] rd; logic er, ot, af;
    xact(0, 0, 14'h0010, 4'hF, 32'hDEADBEEF, 1'b0, lat, rd, er, ot, af);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++; if (ot !== 1'b0) begin errors++; $display("FAIL wr_other_ready: got %b want 0", ot); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL wr_pulse_len: got %b want 0", af); end
    xact(0, 0, 14'h0010, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rd_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", er); end
  endtask

  task automatic test_byte_strobe;
    int lat; logic [31:0] rd; logic er, ot, af;
    xact(0, 0, 14'h0020, 4'hF, 32'h11223344, 1'b0, lat, rd, er, ot, af);
    xact(0, 0, 14'h0020, 4'b0101, 32'hAABBCCDD, 1'b0, lat, rd, er, ot, af);
    xact(0, 0, 14'h0020, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_data: got %h want 11bb33dd", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL strobe_err: got %b want 0", er); end
  endtask

  task automatic test_latch;
    int lat; logic [31:0] rd; logic er, ot, af;
    xact(0, 1, 14'h0030, 4'hF, 32'h55AA55AA, 1'b1, lat, rd, er, ot, af);
    xact(0, 1, 14'h0030, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (rd !== 32'h55AA55AA) begin errors++; $display("FAIL latch_orig: got %h want 55aa55aa", rd); end
    xact(0, 1, 14'h0034, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL latch_moved: got %h want 0", rd); end
    checks++; if (s_rdata[0][0] !== 32'h11BB33DD) begin errors++; $display("FAIL hold_p0_rdata: got %h want 11bb33dd", s_rdata[0][0]); end
  endtask

  task automatic test_back_to_back;
    int order[$]; int stamp[$]; int both; int dbl; logic prev0, prev1;
    do_reset(0);
    both = 0; dbl = 0; prev0 = 1'b0; prev1 = 1'b0;
    s_addr[0][0] = 14'h0100; s_wstrb[0][0] = 4'hF; s_wdata[0][0] = 32'h01010101;
    s_addr[0][1] = 14'h0100; s_wstrb[0][1] = 4'h0; s_wdata[0][1] = 32'h0;
    s_valid[0][0] = 1'b1; s_valid[0][1] = 1'b1;
    for (int c = 1; c <= 40 && order.size() < 4; c++) begin
      @(posedge clk); #1;
      if (s_ready[0][0] && s_ready[0][1]) both++;
      if ((s_ready[0][0] && prev0) || (s_ready[0][1] && prev1)) dbl++;
      if (s_ready[0][0]) begin order.push_back(0); stamp.push_back(c); end
      else if (s_ready[0][1]) begin order.push_back(1); stamp.push_back(c); end
      prev0 = s_ready[0][0]; prev1 = s_ready[0][1];
    end
    s_valid[0][0] = 1'b0; s_valid[0][1] = 1'b0;
    @(posedge clk); #1;
    if ((s_ready[0][0] && prev0) || (s_ready[0][1] && prev1)) dbl++;
    checks++; if (order.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", order.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((i < order.size() ? order[i] : -1) !== i % 2) begin
        errors++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, (i < order.size() ? order[i] : -1), i % 2);
      end
      checks++;
      if ((i < stamp.size() ? stamp[i] : -1) !== 2 + 3 * i) begin
        errors++; $display("FAIL b2b_cycle[%0d]: got %0d want %0d", i, (i < stamp.size() ? stamp[i] : -1), 2 + 3 * i);
      end
    end
    checks++; if (both !== 0) begin errors++; $display("FAIL b2b_both_ready: got %0d want 0", both); end
    checks++; if (dbl !== 0) begin errors++; $display("FAIL b2b_pulse_len: got %0d want 0", dbl); end
    checks++; if (s_rdata[0][1] !== 32'h01010101) begin errors++; $display("FAIL b2b_p1_rdata: got %h want 01010101", s_rdata[0][1]); end
  endtask

  task automatic test_out_of_range;
    int lat; logic [31:0] rd; logic er, ot, af;
    xact(0, 0, 14'h0020, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL mem_survives_reset: got %h want 11bb33dd", rd); end
    xact(0, 0, 14'h2000, 4'hF, 32'hFFFFFFFF, 1'b0, lat, rd, er, ot, af);
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_wr_latency: got %0d want 2", lat); end
    xact(0, 0, 14'h2000, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_rd_latency: got %0d want 2", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h want 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL oor_rd_err: got %b want 0", er); end
    xact(0, 0, 14'h0000, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_no_alias: got %h want 0", rd); end
  endtask

`ifdef SRAM_PARITY_EN
  task automatic test_parity;
    int lat; logic [31:0] rd; logic er, ot, af;
    dut0.mem[4][9] = ~dut0.mem[4][9];
    xact(0, 0, 14'h0010, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (lat !== 2) begin errors++; $display("FAIL par_latency: got %0d want 2", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL par_err: got %b want 1", er); end
    checks++; if (rd !== 32'hDEADBCEF) begin errors++; $display("FAIL par_data: got %h want deadbcef", rd); end
  endtask
`endif

  task automatic test_wait_states;
    int lat; logic [31:0] rd; logic er, ot, af;
    xact(1, 0, 14'h0008, 4'hF, 32'h12345678, 1'b0, lat, rd, er, ot, af);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ws_wr_latency: got %0d want 5", lat); end
    xact(1, 0, 14'h0008, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL ws_p0_data: got %h want 12345678", rd); end
    xact(1, 1, 14'h000C, 4'hF, 32'h0BADCAFE, 1'b0, lat, rd, er, ot, af);
    xact(1, 1, 14'h000C, 4'h0, 32'h0, 1'b0, lat, rd, er, ot, af);
    checks++; if (lat !== 5) begin errors++; $display("FAIL ws_p1_latency: got %0d want 5", lat); end
    checks++; if (rd !== 32'h0BADCAFE) begin errors++; $display("FAIL ws_p1_data: got %h want 0badcafe", rd); end
    checks++; if (af !== 1'b0) begin errors++; $display("FAIL ws_pulse_len: got %b want 0", af); end
    checks++; if (s_rdata[1][0] !== 32'h12345678) begin errors++; $display("FAIL ws_p0_hold: got %h want 12345678", s_rdata[1][0]); end
  endtask

  task automatic test_reset_mid;
    int seen; int lat; int first; int got1; logic [31:0] rd;
    s_addr[1][0] = 14'h0040; s_wstrb[1][0] = 4'hF; s_wdata[1][0] = 32'hCAFEF00D;
    s_valid[1][0] = 1'b1;
    @(posedge clk); #1;
    s_reset[1] = 1'b1; s_valid[1][0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (s_ready[1][0] !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b want 0", s_ready[1][0]); end
    s_reset[1] = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (s_ready[1][0] || s_ready[1][1]) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_pulse: got %0d want 0", seen); end
    s_addr[1][0] = 14'h0040; s_wstrb[1][0] = 4'h0;
    s_addr[1][1] = 14'h0044; s_wstrb[1][1] = 4'h0;
    s_valid[1][0] = 1'b1; s_valid[1][1] = 1'b1;
    first = -1; lat = -1; rd = 32'hFFFFFFFF;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (s_ready[1][0] || s_ready[1][1]) begin
        first = s_ready[1][0] ? 0 : 1; lat = n; rd = s_rdata[1][0];
        break;
      end
    end
    s_valid[1][0] = 1'b0;
    checks++; if (first !== 0) begin errors++; $display("FAIL rst_mid_tie: got port %0d want 0", first); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL rst_mid_latency: got %0d want 5", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_mid_dropped: got %h want 0", rd); end
    got1 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (s_ready[1][1]) begin got1 = 1; break; end
    end
    s_valid[1][1] = 1'b0;
    checks++; if (got1 !== 1) begin errors++; $display("FAIL rst_mid_p1_served: got %0d want 1", got1); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_reset[d] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        s_valid[d][p] = 1'b0; s_wstrb[d][p] = '0; s_addr[d][p] = '0; s_wdata[d][p] = '0;
      end
    end
    test_reset;
    test_write_read;
    test_byte_strobe;
    test_latch;
    test_back_to_back;
    test_out_of_range;
`ifdef SRAM_PARITY_EN
    test_parity;
`endif
    test_wait_states;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
